// File: rtl/tinycpu_mem_arbiter_pkg.sv
// Shared definitions for the TinyCPU memory arbiter.
//   DEF_*      default parameter values for the arbiter and its grant picker
//   STREAK_W   width of the LS-grant streak counter
//   LAT_W      width of the memory latency down-counter
//   arb_state_t  sequencer state encoding
package tinycpu_mem_arbiter_pkg;

   localparam int DEF_AW         = 8;
   localparam int DEF_DW         = 16;
   localparam int DEF_MEM_LAT    = 1;
   localparam int DEF_STARVE_MAX = 3;
   localparam int STREAK_W       = 4;
   localparam int LAT_W          = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } arb_state_t;

endpackage

// File: rtl/tinycpu_arb_pick.sv
// Grant picker for the TinyCPU memory arbiter: LS priority with an IF
// starvation guard.
//   clk, rst_n  clock, async active-low reset
//   if_req      fetch port request
//   ls_req      load/store port request
//   take        a grant is being taken this cycle (arbiter idle, some request)
//   grant_ls    LS wins arbitration this cycle
//   grant_if    IF wins arbitration this cycle
module tinycpu_arb_pick
   import tinycpu_mem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic clk,
   input  logic rst_n,
   input  logic if_req,
   input  logic ls_req,
   input  logic take,
   output logic grant_ls,
   output logic grant_if
);

   localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(STARVE_MAX);

   logic [STREAK_W-1:0] streak;
   logic [STREAK_W-1:0] streak_d;
   logic                starved;

   always_comb begin
      starved  = if_req && (streak == STREAK_CAP);
      grant_ls = ls_req && !starved;
      grant_if = if_req && !grant_ls;
      streak_d = streak;
      if (take) begin
         if (grant_if) begin
            streak_d = '0;
         end else if (if_req) begin
            // LS won while IF was waiting: one step closer to forcing IF
            streak_d = (streak == STREAK_CAP) ? streak : streak + 1'b1;
         end else begin
            streak_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak <= '0;
      end else begin
         streak <= streak_d;
      end
   end

endmodule

// File: rtl/tinycpu_mem_arbiter.sv
// Shares one single-port synchronous memory between the TinyCPU fetch (IF)
// and load/store (LS) ports. Each access runs issue -> latency wait -> ack.
// All outputs are registered.
//   clk, rst_n                  clock, async active-low reset
//   if_req/if_addr              fetch request and address (always a read)
//   if_ack/if_rdata             fetch done pulse and captured fetch data
//   ls_req/ls_we/ls_addr/ls_wdata  load/store request
//   ls_ack/ls_rdata             load/store done pulse and captured load data
//   mem_en/mem_we/mem_addr/mem_wdata  memory command, one mem_en cycle per access
//   mem_rdata                   memory read data, valid MEM_LAT cycles after mem_en
//   busy                        high whenever the sequencer is not idle
//
// state | meaning
// IDLE  | arbitrate; take a grant if any request is present
// ISSUE | mem_en high for the granted access
// WAIT  | count memory latency, capture read data on the last cycle
// ACK   | ack pulse to the granted port
module tinycpu_mem_arbiter
   import tinycpu_mem_arbiter_pkg::*;
#(
   parameter int AW         = DEF_AW,
   parameter int DW         = DEF_DW,
   parameter int MEM_LAT    = DEF_MEM_LAT,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          ls_req,
   input  logic          ls_we,
   input  logic [AW-1:0] ls_addr,
   input  logic [DW-1:0] ls_wdata,
   output logic          ls_ack,
   output logic [DW-1:0] ls_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

   arb_state_t       state, state_d;
   logic [LAT_W-1:0] lat_cnt, lat_cnt_d;
   logic             gnt_if, gnt_if_d;
   logic             if_ack_d, ls_ack_d;
   logic [DW-1:0]    if_rdata_d, ls_rdata_d;
   logic             mem_en_d, mem_we_d;
   logic [AW-1:0]    mem_addr_d;
   logic [DW-1:0]    mem_wdata_d;
   logic             busy_d;
   logic             take, grant_ls, grant_if;

   assign take = (state == ST_IDLE) && (if_req || ls_req);

   tinycpu_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req),
      .ls_req   (ls_req),
      .take     (take),
      .grant_ls (grant_ls),
      .grant_if (grant_if)
   );

   always_comb begin
      state_d     = state;
      lat_cnt_d   = lat_cnt;
      gnt_if_d    = gnt_if;
      if_ack_d    = 1'b0;
      ls_ack_d    = 1'b0;
      if_rdata_d  = if_rdata;
      ls_rdata_d  = ls_rdata;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      case (state)
         ST_IDLE: begin
            // Command is latched here so a requester dropping its inputs
            // mid-access cannot disturb the access in flight.
            if (grant_if) begin
               state_d    = ST_ISSUE;
               gnt_if_d   = 1'b1;
               mem_en_d   = 1'b1;
               mem_addr_d = if_addr;
            end else if (grant_ls) begin
               state_d     = ST_ISSUE;
               gnt_if_d    = 1'b0;
               mem_en_d    = 1'b1;
               mem_we_d    = ls_we;
               mem_addr_d  = ls_addr;
               mem_wdata_d = ls_wdata;
            end
         end
         ST_ISSUE: begin
            if (mem_we) begin
               state_d  = ST_ACK;
               if_ack_d = gnt_if;
               ls_ack_d = !gnt_if;
            end else begin
               state_d   = ST_WAIT;
               lat_cnt_d = LAT_INIT;
            end
         end
         ST_WAIT: begin
            if (lat_cnt == '0) begin
               state_d  = ST_ACK;
               if_ack_d = gnt_if;
               ls_ack_d = !gnt_if;
               if (gnt_if) begin
                  if_rdata_d = mem_rdata;
               end else begin
                  ls_rdata_d = mem_rdata;
               end
            end else begin
               lat_cnt_d = lat_cnt - 1'b1;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_cnt   <= '0;
         gnt_if    <= 1'b0;
         if_ack    <= 1'b0;
         ls_ack    <= 1'b0;
         if_rdata  <= '0;
         ls_rdata  <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
      end else begin
         lat_cnt   <= lat_cnt_d;
         gnt_if    <= gnt_if_d;
         if_ack    <= if_ack_d;
         ls_ack    <= ls_ack_d;
         if_rdata  <= if_rdata_d;
         ls_rdata  <= ls_rdata_d;
         mem_en    <= mem_en_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         busy      <= busy_d;
      end
   end

endmodule

// File: tb/tb_tinycpu_mem_arbiter.sv
// Directed bench for tinycpu_mem_arbiter: one instance with MEM_LAT=1 and one
// with MEM_LAT=4, each backed by a small latency-pipelined memory model that
// drives random garbage on mem_rdata outside the valid cycle.
module tb_tinycpu_mem_arbiter;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        if_req, ls_req, ls_we;
   logic [7:0]  if_addr, ls_addr, mem_addr;
   logic [15:0] ls_wdata, if_rdata, ls_rdata, mem_wdata, mem_rdata;
   logic        if_ack, ls_ack, mem_en, mem_we, busy;

   logic        if_req_b, ls_req_b, ls_we_b;
   logic [7:0]  if_addr_b, ls_addr_b, mem_addr_b;
   logic [15:0] ls_wdata_b, if_rdata_b, ls_rdata_b, mem_wdata_b, mem_rdata_b;
   logic        if_ack_b, ls_ack_b, mem_en_b, mem_we_b, busy_b;

   tinycpu_mem_arbiter #(.AW(8), .DW(16), .MEM_LAT(1), .STARVE_MAX(3)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_ack(ls_ack), .ls_rdata(ls_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   tinycpu_mem_arbiter #(.AW(8), .DW(16), .MEM_LAT(4), .STARVE_MAX(3)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req_b), .if_addr(if_addr_b), .if_ack(if_ack_b), .if_rdata(if_rdata_b),
      .ls_req(ls_req_b), .ls_we(ls_we_b), .ls_addr(ls_addr_b), .ls_wdata(ls_wdata_b),
      .ls_ack(ls_ack_b), .ls_rdata(ls_rdata_b),
      .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .mem_rdata(mem_rdata_b), .busy(busy_b)
   );

   // Memory models
   logic [15:0] mem_a [256];
   logic [15:0] mem_b [256];
   logic [15:0] garb;
   logic [15:0] pa_d;
   logic        pa_v;
   logic [15:0] pb_d [4];
   logic [3:0]  pb_v;

   always @(posedge clk) begin
      garb <= 16'($urandom);
      if (mem_en && mem_we) mem_a[mem_addr] <= mem_wdata;
      pa_d <= mem_a[mem_addr];
      pa_v <= mem_en && !mem_we;
      if (mem_en_b && mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
      pb_d[0] <= mem_b[mem_addr_b];
      pb_d[1] <= pb_d[0];
      pb_d[2] <= pb_d[1];
      pb_d[3] <= pb_d[2];
      pb_v    <= {pb_v[2:0], mem_en_b && !mem_we_b};
   end

   assign mem_rdata   = pa_v    ? pa_d    : garb;
   assign mem_rdata_b = pb_v[3] ? pb_d[3] : ~garb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_store(input logic [7:0] a, input logic [15:0] d);
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = a; ls_wdata = d;
      tick();
      chk("st_mem_en", mem_en, 1'b1);
      chk("st_mem_we", mem_we, 1'b1);
      chk("st_mem_addr", mem_addr, a);
      chk("st_mem_wdata", mem_wdata, d);
      tick();
      chk("st_ls_ack", ls_ack, 1'b1);
      chk("st_if_ack", if_ack, 1'b0);
      ls_req = 1'b0; ls_we = 1'b0;
      tick();
      chk("st_ack_drop", ls_ack, 1'b0);
      chk("st_busy_end", busy, 1'b0);
   endtask

   task automatic do_ls_load(input logic [7:0] a, input logic [15:0] e);
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = a;
      tick();
      chk("ld_mem_en", mem_en, 1'b1);
      chk("ld_mem_we", mem_we, 1'b0);
      chk("ld_mem_addr", mem_addr, a);
      tick();
      chk("ld_early_ack", ls_ack, 1'b0);
      tick();
      chk("ld_ls_ack", ls_ack, 1'b1);
      chk("ld_ls_rdata", ls_rdata, e);
      ls_req = 1'b0;
      tick();
      chk("ld_busy_end", busy, 1'b0);
   endtask

   task automatic do_if_load(input logic [7:0] a, input logic [15:0] e);
      if_req = 1'b1; if_addr = a;
      tick();
      chk("if_mem_en", mem_en, 1'b1);
      chk("if_mem_we", mem_we, 1'b0);
      chk("if_mem_addr", mem_addr, a);
      tick();
      chk("if_early_ack", if_ack, 1'b0);
      tick();
      chk("if_ack", if_ack, 1'b1);
      chk("if_ls_ack", ls_ack, 1'b0);
      chk("if_rdata", if_rdata, e);
      if_req = 1'b0;
      tick();
      chk("if_ack_drop", if_ack, 1'b0);
      chk("if_busy_end", busy, 1'b0);
   endtask

   int k, cyc, n, en_at;
   bit got;

   initial begin
      if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
      if_req_b = 0; if_addr_b = '0; ls_req_b = 0; ls_we_b = 0; ls_addr_b = '0; ls_wdata_b = '0;
      tick();
      tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_if_ack", if_ack, 1'b0);
      chk("rst_ls_ack", ls_ack, 1'b0);
      chk("rst_if_rdata", if_rdata, 16'h0);
      chk("rst_ls_rdata", ls_rdata, 16'h0);
      chk("rst_mem_addr", mem_addr, 8'h0);
      rst_n = 1'b1;
      tick();

      // Stores, loads, ls_rdata untouched by a store
      do_store(8'h10, 16'hBEEF);
      do_ls_load(8'h10, 16'hBEEF);
      do_store(8'h22, 16'h1234);
      chk("ls_rdata_after_store", ls_rdata, 16'hBEEF);
      do_ls_load(8'h22, 16'h1234);

      // Single IF load, MEM_LAT=1
      do_if_load(8'h10, 16'hBEEF);

      // Reset asserted mid-WAIT
      if_req = 1'b1; if_addr = 8'h22;
      tick();
      chk("rw_issue", mem_en, 1'b1);
      tick();
      chk("rw_wait_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rw_busy_async", busy, 1'b0);
      chk("rw_mem_en", mem_en, 1'b0);
      chk("rw_if_ack", if_ack, 1'b0);
      if_req = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rw_no_ack", if_ack | ls_ack, 1'b0);
      end
      do_if_load(8'h22, 16'h1234);

      // Reset asserted in ISSUE drops mem_en without waiting for an edge
      if_req = 1'b1; if_addr = 8'h10;
      tick();
      chk("ri_mem_en", mem_en, 1'b1);
      rst_n = 1'b0;
      if_req = 1'b0;
      #1;
      chk("ri_mem_en_async", mem_en, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();

      // Both requesting continuously: LS,LS,LS,IF repeating
      if_req = 1'b1; if_addr = 8'h10;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h22;
      k = 0; cyc = 0;
      while (k < 8 && cyc < 100) begin
         tick();
         cyc++;
         chk("ack_overlap", if_ack & ls_ack, 1'b0);
         if (mem_en) begin
            chk("grant_order", mem_addr == 8'h10, (k % 4) == 3);
            k++;
         end
      end
      if_req = 1'b0; ls_req = 1'b0;
      chk("grant_count", k, 8);
      repeat (3) tick();
      chk("arb_busy_end", busy, 1'b0);
      chk("arb_if_rdata", if_rdata, 16'hBEEF);
      chk("arb_ls_rdata", ls_rdata, 16'h1234);

      // ls_req dropped in the ISSUE cycle
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h10;
      tick();
      chk("drop_issue", mem_en, 1'b1);
      ls_req = 1'b0; ls_addr = 8'hFF;
      tick();
      tick();
      chk("drop_ack", ls_ack, 1'b1);
      chk("drop_rdata", ls_rdata, 16'hBEEF);
      tick();
      chk("drop_ack_once", ls_ack, 1'b0);
      chk("drop_busy", busy, 1'b0);
      repeat (2) begin
         tick();
         chk("drop_no_regrant", mem_en | ls_ack, 1'b0);
      end

      // MEM_LAT=4 instance: IF load acks 6 cycles after sampling
      ls_req_b = 1'b1; ls_we_b = 1'b1; ls_addr_b = 8'h40; ls_wdata_b = 16'h5A5A;
      tick();
      tick();
      chk("b_st_ack", ls_ack_b, 1'b1);
      ls_req_b = 1'b0; ls_we_b = 1'b0;
      tick();
      if_req_b = 1'b1; if_addr_b = 8'h40;
      n = 0; en_at = 0; got = 1'b0;
      while (n < 20 && !got) begin
         tick();
         n++;
         if (mem_en_b && en_at == 0) en_at = n;
         if (if_ack_b) got = 1'b1;
      end
      if_req_b = 1'b0;
      chk("b_ack_latency", n, 6);
      chk("b_mem_en_at", en_at, 1);
      chk("b_if_rdata", if_rdata_b, 16'h5A5A);
      repeat (3) tick();
      chk("b_if_rdata_hold", if_rdata_b, 16'h5A5A);
      chk("b_busy_end", busy_b, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
